pe_code_decoder: RTL
====================

Name: pe_code_decoder

Overview:
- Receiving end of the 3-line priority encoder interface: takes the 2-bit encoded index (o2,o1 order, MSB first) plus a valid strobe.
- Buffers codes in a 2-entry skid stage with valid/ready handshake and decodes each one to a registered one-hot line vector.
- Keeps saturating per-line event counters for debug and bring-up.
- Sits downstream of the encoder (PE / PEDataFlow / PEBhv family) in the same clk domain.

Parameters:
- CNT_W, 8, width of each per-line event counter.
- DROP_NONE, 1, 1 = code 2'b00 (no request) is accepted and discarded; 0 = forwarded as out_lines 3'b000.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  2  encoded index: 00 none, 01 line1, 10 line2, 11 line3 (line3 highest priority).
- in_ready  output  1  decoder can accept a code this cycle.
- out_valid  output  1  out_lines holds a decoded item.
- out_lines  output  3  one-hot decode, bit0 = line1, bit2 = line3.
- out_ready  input  1  downstream accepts the item this cycle.
- clr_cnt  input  1  synchronous clear of all counters.
- cnt_l1  output  CNT_W  saturating count of line1 transfers out.
- cnt_l2  output  CNT_W  saturating count of line2 transfers out.
- cnt_l3  output  CNT_W  saturating count of line3 transfers out.
- cnt_none  output  CNT_W  saturating count of accepted 2'b00 codes.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_valid=0, out_lines=3'b000, skid empty, in_ready=1 from the first edge after rst_n rises, all counters=0. Reset mid-transfer discards buffered items with no output.
- Accept: a code is accepted when in_valid && in_ready at a rising edge.
- Transfer: a transfer out occurs when out_valid && out_ready at a rising edge.
- Storage: output register plus one skid register, 2 items total.
- Latency: code accepted at edge N with the output register free (or draining at N) → out_valid=1 and decoded lines in cycle N+1.
- in_ready is registered and equals !skid_full. It drops only when the output is held (out_valid && !out_ready) and a new code is accepted into the skid.
- Skid fill: if the output is stalled and a code is accepted, it goes into the skid.
- Skid drain: on the next transfer out, skid → output register, and in_ready returns to 1 in the following cycle.
- Simultaneous accept and transfer with the skid empty: the new code loads directly into the output register, so throughput is 1/cycle.
- Ordering: strict FIFO; an item is never duplicated or dropped except under the DROP_NONE rule.
- out_lines must be stable while out_valid && !out_ready.
- Decode: 01→001, 10→010, 11→100. 00 → 000 if DROP_NONE=0.
- If DROP_NONE=1, code 00 never occupies storage, is always accepted when in_ready=1, and increments cnt_none at the accept edge.
- Counters cnt_l1..3 increment on the transfer-out edge of the matching line. They saturate at 2^CNT_W−1 with no wrap.
- cnt_none counts at accept regardless of DROP_NONE.
- clr_cnt=1 zeroes all counters at the next edge and has priority over a same-cycle increment.
- in_code is ignored when in_valid=0. A code of X with in_valid=1 is a bench error; no RTL check.

Decomposition:
- Package pe_pkg: CODE_NONE=2'b00, CODE_L1=2'b01, CODE_L2=2'b10, CODE_L3=2'b11, N_LINES=3, and a decode function code→one-hot.
- One sub-module, pe_skid_buf: a generic 2-entry valid/ready skid buffer parameterised on data width, instantiated with width 2 on the code.
- Decode, drop filter and counters live in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → out_valid=0, out_lines=000, counters=0, in_ready=1.
- Streaming: out_ready=1, send codes 01,10,11 on consecutive cycles → out_lines 001,010,100 in cycles N+1..N+3, then cnt_l1=cnt_l2=cnt_l3=1.
- Backpressure: out_ready=0, send 11 then 01 → in_ready drops after the second accept and a third code is not accepted. Raise out_ready → outputs 100 then 001 in order, in_ready back to 1.
- DROP_NONE=1: send 00,10,00 → only one output item, 010; cnt_none=2. With DROP_NONE=0 the same stimulus gives 000,010,000.
- Saturation, CNT_W=4: 20 line2 transfers → cnt_l2=15. Assert clr_cnt on the same edge as a transfer → cnt_l2=0.
- Async reset: assert rst_n low mid-cycle with both entries full → out_valid and in_ready respond without a clock edge. After release, the buffered codes never appear at the output.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the priority-encoder receive path.
// Contents:
//   CODE_*       encoded index values as produced by the 3-line encoder
//                (o2,o1 order, MSB first; line3 has the highest priority)
//   N_LINES      number of request lines behind the encoder
//   pe_decode    code -> one-hot line vector (bit0 = line1, bit2 = line3)
package pe_pkg;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_L1   = 2'b01;
  localparam logic [1:0] CODE_L2   = 2'b10;
  localparam logic [1:0] CODE_L3   = 2'b11;

  localparam int N_LINES = 3;

  // "No request" decodes to an all-zero vector so that, when it is forwarded,
  // downstream sees an item with no line asserted.
  function automatic logic [N_LINES-1:0] pe_decode(input logic [1:0] code);
    logic [N_LINES-1:0] lines;
    lines = '0;
    case (code)
      CODE_L1: lines = 3'b001;
      CODE_L2: lines = 3'b010;
      CODE_L3: lines = 3'b100;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/pe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// Storage is an output register plus one skid register. in_ready is a flop
// (no combinational path from out_ready to in_ready); it equals !skid_full.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     upstream item offered this cycle
//   in_ready              buffer can take an item this cycle
//   out_valid, out_data   head item presented downstream (held while stalled)
//   out_ready             downstream takes the head item this cycle
module pe_skid_buf #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,  in_ready_d;

  logic accept;
  logic xfer;

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (!out_valid_q || xfer) begin
      // Output register is free (or being emptied this edge): refill it,
      // oldest item first. A full skid implies in_ready_q=0, so accept and
      // skid drain never collide here.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new item in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    in_ready_d = !skid_valid_d;
  end

  // in_ready_q comes out of reset low and rises on the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/pe_code_decoder.sv
// Receive side of the 3-line priority encoder interface.
// Accepts 2-bit encoded indices through a 2-entry skid buffer, presents each
// buffered code as a one-hot line vector, and keeps saturating per-line event
// counters for bring-up.
// Parameters:
//   CNT_W      width of each event counter
//   DROP_NONE  1: code 00 is accepted and discarded; 0: forwarded as 3'b000
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid, in_code      encoded index offered this cycle
//   in_ready               a code can be accepted this cycle (registered)
//   out_valid, out_lines   decoded one-hot item (bit0 = line1, bit2 = line3)
//   out_ready              downstream accepts the item this cycle
//   clr_cnt                synchronous clear of all counters (wins over increments)
//   cnt_l1/l2/l3           line transfers out, saturating
//   cnt_none               accepted 00 codes, saturating
module pe_code_decoder
  import pe_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter bit          DROP_NONE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2:0]       out_lines,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_l1,
  output logic [CNT_W-1:0] cnt_l2,
  output logic [CNT_W-1:0] cnt_l3,
  output logic [CNT_W-1:0] cnt_none
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic       is_none;
  logic       drop_code;
  logic       buf_in_valid;
  logic       buf_in_ready;
  logic       buf_out_valid;
  logic [1:0] out_code;
  logic       accept_none;
  logic       xfer_out;

  assign is_none   = (in_code == CODE_NONE);
  // A dropped 00 still handshakes on in_ready but never enters storage.
  assign drop_code = DROP_NONE && is_none;
  assign buf_in_valid = in_valid && !drop_code;

  pe_skid_buf #(
    .DATA_W (2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (buf_in_valid),
    .in_data   (in_code),
    .in_ready  (buf_in_ready),
    .out_valid (buf_out_valid),
    .out_data  (out_code),
    .out_ready (out_ready)
  );

  assign in_ready    = buf_in_ready;
  assign out_valid   = buf_out_valid;
  // Pure decode of the registered head code: stable while the output stalls.
  assign out_lines   = pe_decode(out_code);

  assign accept_none = in_valid && buf_in_ready && is_none;
  assign xfer_out    = buf_out_valid && out_ready;

  logic [CNT_W-1:0] cnt_l1_q,   cnt_l1_d;
  logic [CNT_W-1:0] cnt_l2_q,   cnt_l2_d;
  logic [CNT_W-1:0] cnt_l3_q,   cnt_l3_d;
  logic [CNT_W-1:0] cnt_none_q, cnt_none_d;

  always_comb begin
    cnt_l1_d   = cnt_l1_q;
    cnt_l2_d   = cnt_l2_q;
    cnt_l3_d   = cnt_l3_q;
    cnt_none_d = cnt_none_q;
    if (clr_cnt) begin
      cnt_l1_d   = '0;
      cnt_l2_d   = '0;
      cnt_l3_d   = '0;
      cnt_none_d = '0;
    end else begin
      if (xfer_out && (out_code == CODE_L1)) cnt_l1_d = sat_inc(cnt_l1_q);
      if (xfer_out && (out_code == CODE_L2)) cnt_l2_d = sat_inc(cnt_l2_q);
      if (xfer_out && (out_code == CODE_L3)) cnt_l3_d = sat_inc(cnt_l3_q);
      // Counted at accept, whether or not the code is forwarded.
      if (accept_none) cnt_none_d = sat_inc(cnt_none_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_l1_q   <= '0;
      cnt_l2_q   <= '0;
      cnt_l3_q   <= '0;
      cnt_none_q <= '0;
    end else begin
      cnt_l1_q   <= cnt_l1_d;
      cnt_l2_q   <= cnt_l2_d;
      cnt_l3_q   <= cnt_l3_d;
      cnt_none_q <= cnt_none_d;
    end
  end

  assign cnt_l1   = cnt_l1_q;
  assign cnt_l2   = cnt_l2_q;
  assign cnt_l3   = cnt_l3_q;
  assign cnt_none = cnt_none_q;

endmodule
